// File: rtl/rt_multi_worker.sv
// -----------------------------------------------------------------------------
// rt_multi_worker
//   One ray-tracing worker. On an accepted start it walks JOBS pixels of one
//   row (x = pixel_start_x + j*STRIDE). For each pixel it tests the spheres in
//   ascending index order with the ray/sphere discriminant
//       a = px^2+py^2+Z^2, b = 2(px*sx+py*sy+Z*sz), c = sx^2+sy^2+sz^2-r^2
//       dis = b^2 - 4ac
//   The first sphere with dis >= 0 decides the pixel colour. A pixel with no
//   hit stays 0.
//
//   Build option: define RT_SHADING_EN to add the SHADE state. A hit then gets
//   colour min(floor(log2(dis))+1, COLOR_MAX), with dis==0 giving 1. Without
//   RT_SHADING_EN every hit gets COLOR_MAX and each sphere costs one cycle less.
//
//   Ports
//     clk, rst        rising-edge clock, asynchronous active-high reset
//     start           one-cycle job request; only honoured while idle
//     pixel_start_x   x of pixel 0 (signed 12 bit), captured at start
//     pixel_y         row y (signed 12 bit), captured at start
//     spheres         scene, held stable by the source while busy
//     busy            high from the cycle after an accepted start until done
//     done            one-cycle pulse together with the final buffer value
//     buffer          per-pixel colours, entry j = pixel_start_x + j*STRIDE
// -----------------------------------------------------------------------------
package Types;
    typedef struct packed {
        logic signed [11:0] x;
        logic signed [11:0] y;
        logic signed [11:0] z;
        logic signed [11:0] r;
    } Sphere;
endpackage

module rt_multi_worker #(
    parameter int JOBS      = 8,
    parameter int STRIDE    = 4,
    parameter int N_SPHERES = 4,
    parameter int PIXEL_Z   = 100,
    parameter int COLOR_W   = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic signed [11:0]               pixel_start_x,
    input  logic signed [11:0]               pixel_y,
    input  Types::Sphere                     spheres [N_SPHERES],
    output logic                             busy,
    output logic                             done,
    output logic [JOBS-1:0][COLOR_W-1:0]     buffer
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] SQUARE = 3'd1;
    localparam logic [2:0] DOT    = 3'd2;
    localparam logic [2:0] SUM    = 3'd3;
    localparam logic [2:0] DISC   = 3'd4;
    localparam logic [2:0] SHADE  = 3'd5;
    localparam logic [2:0] NEXT   = 3'd6;

    localparam int IW = (N_SPHERES > 1) ? $clog2(N_SPHERES) : 1;
    localparam int JW = (JOBS > 1) ? $clog2(JOBS) : 1;

    localparam logic signed [63:0] STRIDE_W  = 64'(STRIDE);
    localparam logic signed [63:0] Z_W       = 64'(PIXEL_Z);
    localparam logic signed [63:0] ZZ_W      = Z_W * Z_W;
    localparam logic [COLOR_W-1:0] COLOR_MAX = '1;

    // All arithmetic is carried at 64 bits so no intermediate can wrap for
    // 12-bit inputs; the discriminant stays well inside the signed range.
    function automatic logic signed [63:0] ext12(input logic signed [11:0] v);
        return {{52{v[11]}}, v};
    endfunction

`ifdef RT_SHADING_EN
    // Leading-one encoder: position of the highest set bit plus one, saturated.
    function automatic logic [COLOR_W-1:0] shade(input logic [63:0] d);
        logic [31:0] lvl;
        lvl = 32'd1;
        for (int i = 0; i < 64; i++) begin
            if (d[i]) lvl = 32'(i) + 32'd1;
        end
        if (lvl > 32'(COLOR_MAX)) return COLOR_MAX;
        else                      return COLOR_W'(lvl);
    endfunction
`endif

    logic [2:0]           state_r;
    logic [JW-1:0]        job_r;
    logic [IW-1:0]        sph_idx_r;
    logic signed [63:0]   px_r, py_r;
    logic signed [63:0]   pxx_r, pyy_r, sxx_r, syy_r, szz_r, rr_r;
    logic signed [63:0]   pxsx_r, pysy_r, zsz_r;
    logic signed [63:0]   a_r, b_r, c_r, dis_r;
    logic [COLOR_W-1:0]   color_r;

    Types::Sphere         sph_s;
    logic signed [63:0]   sx_s, sy_s, sz_s, r_s, dis_s;
    logic                 last_sph_s, last_job_s;

    // Select the sphere currently under test.
    always_comb begin
        sph_s = spheres[0];
        for (int i = 1; i < N_SPHERES; i++) begin
            sph_s = (sph_idx_r == IW'(i)) ? spheres[i] : sph_s;
        end
    end

    assign sx_s       = ext12(sph_s.x);
    assign sy_s       = ext12(sph_s.y);
    assign sz_s       = ext12(sph_s.z);
    assign r_s        = ext12(sph_s.r);
    assign dis_s      = b_r * b_r - 64'sd4 * a_r * c_r;
    assign last_sph_s = (sph_idx_r == IW'(N_SPHERES - 1));
    assign last_job_s = (job_r == JW'(JOBS - 1));

    // Job sequencer and discriminant datapath.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            buffer    <= '0;
            job_r     <= '0;
            sph_idx_r <= '0;
            px_r      <= 64'sd0;
            py_r      <= 64'sd0;
            pxx_r     <= 64'sd0;
            pyy_r     <= 64'sd0;
            sxx_r     <= 64'sd0;
            syy_r     <= 64'sd0;
            szz_r     <= 64'sd0;
            rr_r      <= 64'sd0;
            pxsx_r    <= 64'sd0;
            pysy_r    <= 64'sd0;
            zsz_r     <= 64'sd0;
            a_r       <= 64'sd0;
            b_r       <= 64'sd0;
            c_r       <= 64'sd0;
            dis_r     <= 64'sd0;
            color_r   <= '0;
        end else begin
            done <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        px_r      <= ext12(pixel_start_x);
                        py_r      <= ext12(pixel_y);
                        buffer    <= '0;
                        job_r     <= '0;
                        sph_idx_r <= '0;
                        color_r   <= '0;
                        busy      <= 1'b1;
                        state_r   <= SQUARE;
                    end else begin
                        state_r   <= IDLE;
                    end
                end
                SQUARE: begin
                    pxx_r   <= px_r * px_r;
                    pyy_r   <= py_r * py_r;
                    sxx_r   <= sx_s * sx_s;
                    syy_r   <= sy_s * sy_s;
                    szz_r   <= sz_s * sz_s;
                    rr_r    <= r_s * r_s;
                    state_r <= DOT;
                end
                DOT: begin
                    pxsx_r  <= px_r * sx_s;
                    pysy_r  <= py_r * sy_s;
                    zsz_r   <= Z_W * sz_s;
                    state_r <= SUM;
                end
                SUM: begin
                    a_r     <= pxx_r + pyy_r + ZZ_W;
                    b_r     <= 64'sd2 * (pxsx_r + pysy_r + zsz_r);
                    c_r     <= sxx_r + syy_r + szz_r - rr_r;
                    state_r <= DISC;
                end
                DISC: begin
                    dis_r <= dis_s;
`ifdef RT_SHADING_EN
                    state_r <= SHADE;
`else
                    // Without shading the hit decision is taken here directly.
                    if (!dis_s[63]) begin
                        color_r <= COLOR_MAX;
                        state_r <= NEXT;
                    end else if (last_sph_s) begin
                        state_r <= NEXT;
                    end else begin
                        sph_idx_r <= sph_idx_r + IW'(1);
                        state_r   <= SQUARE;
                    end
`endif
                end
                SHADE: begin
                    if (!dis_r[63]) begin
`ifdef RT_SHADING_EN
                        color_r <= shade(dis_r);
`else
                        color_r <= COLOR_MAX;
`endif
                        state_r <= NEXT;
                    end else if (last_sph_s) begin
                        state_r <= NEXT;
                    end else begin
                        sph_idx_r <= sph_idx_r + IW'(1);
                        state_r   <= SQUARE;
                    end
                end
                NEXT: begin
                    for (int j = 0; j < JOBS; j++) begin
                        if (job_r == JW'(j)) buffer[j] <= color_r;
                    end
                    color_r   <= '0;
                    sph_idx_r <= '0;
                    if (last_job_s) begin
                        job_r   <= '0;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state_r <= IDLE;
                    end else begin
                        job_r   <= job_r + JW'(1);
                        px_r    <= px_r + STRIDE_W;
                        state_r <= SQUARE;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rt_multi_worker.sv
// -----------------------------------------------------------------------------
// tb_rt_multi_worker
//   Directed bench for rt_multi_worker. Two instances share clk/rst: dut1 has
//   JOBS=1 for per-pixel latency and colour cases, dut8 has JOBS=8 for the
//   stride/row, ignored-start and mid-job reset cases. Expected colours follow
//   RT_SHADING_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_rt_multi_worker;

`ifdef RT_SHADING_EN
    localparam int         S    = 5;
    localparam logic [7:0] C_S0 = 8'd27;   // dis = 1e8 at pixel (0,0)
    localparam logic [7:0] C_X8 = 8'd23;   // dis = 5862400   (x = +-8)
    localparam logic [7:0] C_X4 = 8'd24;   // dis = 13465600  (x = +-4)
    localparam logic [7:0] C_X0 = 8'd24;   // dis = 16000000  (x = 0)
`else
    localparam int         S    = 4;
    localparam logic [7:0] C_S0 = 8'd255;
    localparam logic [7:0] C_X8 = 8'd255;
    localparam logic [7:0] C_X4 = 8'd255;
    localparam logic [7:0] C_X0 = 8'd255;
`endif
    // Row of 8: x=-16,-12 and 12 miss everything (4S+1 each), five hits (S+1).
    localparam int L8 = 5 * (S + 1) + 3 * (4 * S + 1);

    logic               clk = 1'b0;
    logic               rst;
    logic               start1, start8;
    logic signed [11:0] psx1, py1, psx8, py8;
    Types::Sphere       sph1 [4];
    Types::Sphere       sph8 [4];
    logic               busy1, done1, busy8, done8;
    logic [0:0][7:0]    buf1;
    logic [7:0][7:0]    buf8;
    logic [7:0][7:0]    exp8;
    Types::Sphere       far_s;
    int                 n_assert = 0;
    int                 n_fail   = 0;
    int                 lat;
    int                 ndone;

    always #5 clk = ~clk;

    rt_multi_worker #(.JOBS(1), .STRIDE(4), .N_SPHERES(4), .PIXEL_Z(100), .COLOR_W(8)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .pixel_start_x(psx1), .pixel_y(py1),
        .spheres(sph1), .busy(busy1), .done(done1), .buffer(buf1)
    );

    rt_multi_worker #(.JOBS(8), .STRIDE(4), .N_SPHERES(4), .PIXEL_Z(100), .COLOR_W(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .pixel_start_x(psx8), .pixel_y(py8),
        .spheres(sph8), .busy(busy8), .done(done8), .buffer(buf8)
    );

    function automatic Types::Sphere mk(input int x, input int y, input int z, input int r);
        Types::Sphere s;
        s.x = x[11:0];
        s.y = y[11:0];
        s.z = z[11:0];
        s.r = r[11:0];
        return s;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Start a dut1 job and count edges from the accepting edge to done.
    task automatic go1(output int l);
        @(negedge clk); start1 = 1'b1;
        @(negedge clk); start1 = 1'b0;
        chk("busy1_after_start", 64'(busy1), 64'd1);
        chk("buf1_cleared_on_start", 64'(buf1), 64'd0);
        l = 0;
        while (done1 !== 1'b1 && l < 200) begin
            @(negedge clk); l++;
        end
        chk("busy1_low_at_done", 64'(busy1), 64'd0);
    endtask

    // Wait for dut8 done; optionally pulse start at cycle pulse_at (ignored).
    task automatic wait8(input int pulse_at, output int l);
        l = 0;
        while (done8 !== 1'b1 && l < 600) begin
            @(negedge clk); l++;
            if (l == pulse_at)          start8 = 1'b1;
            else if (l == pulse_at + 1) start8 = 1'b0;
            else                        start8 = start8;
        end
        start8 = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start1 = 1'b0; start8 = 1'b0;
        psx1 = '0; py1 = '0; psx8 = '0; py8 = '0;
        far_s = mk(-2000, 2000, -2000, 1);
        sph1 = '{far_s, far_s, far_s, far_s};
        sph8 = '{far_s, far_s, far_s, far_s};
        exp8 = '0;
        exp8[2] = C_X8; exp8[3] = C_X4; exp8[4] = C_X0; exp8[5] = C_X4; exp8[6] = C_X8;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_busy1", 64'(busy1), 64'd0);
        chk("rst_done1", 64'(done1), 64'd0);
        chk("rst_buf1",  64'(buf1),  64'd0);
        chk("rst_busy8", 64'(busy8), 64'd0);
        chk("rst_buf8",  64'(buf8),  64'd0);
        rst = 1'b0;

        // Sphere 0 hit at pixel (0,0): S+1 cycles
        sph1 = '{mk(0, 0, 200, 50), far_s, far_s, far_s};
        psx1 = 12'sd0; py1 = 12'sd0;
        go1(lat);
        chk("hit0_latency", 64'(lat), 64'(S + 1));
        chk("hit0_color", 64'(buf1[0]), 64'(C_S0));
        @(negedge clk);
        chk("done1_one_cycle", 64'(done1), 64'd0);
        repeat (3) @(negedge clk);
        chk("hit0_color_held", 64'(buf1[0]), 64'(C_S0));

        // Pixel (100,0): every sphere misses, entry stays 0
        psx1 = 12'sd100;
        go1(lat);
        chk("miss_latency", 64'(lat), 64'(4 * S + 1));
        chk("miss_color", 64'(buf1[0]), 64'd0);

        // Spheres 1 and 2 hit, sphere 0 misses: sphere 1 wins, sphere 2 skipped
        sph1 = '{far_s, mk(0, 0, 200, 50), mk(0, 0, 300, 100), far_s};
        psx1 = 12'sd0;
        go1(lat);
        chk("prio_latency", 64'(lat), 64'(2 * S + 1));
        chk("prio_color", 64'(buf1[0]), 64'(C_S0));

        // Row of 8 from x=-16, inputs changed after acceptance, start mid-job
        sph8 = '{mk(0, 0, 200, 20), far_s, far_s, far_s};
        psx8 = -12'sd16; py8 = 12'sd0;
        @(negedge clk); start8 = 1'b1;
        @(negedge clk); start8 = 1'b0;
        psx8 = 12'sd500; py8 = 12'sd300;
        chk("busy8_after_start", 64'(busy8), 64'd1);
        wait8(10, lat);
        chk("row_latency", 64'(lat), 64'(L8));
        chk("row_buffer", 64'(buf8), 64'(exp8));
        ndone = 1;
        repeat (20) begin
            @(negedge clk);
            if (done8 === 1'b1) ndone++;
            else                ndone = ndone;
        end
        chk("row_done_count", 64'(ndone), 64'd1);
        chk("row_busy_idle", 64'(busy8), 64'd0);

        // Reset during pixel 3
        psx8 = -12'sd16; py8 = 12'sd0;
        @(negedge clk); start8 = 1'b1;
        @(negedge clk); start8 = 1'b0;
        repeat (9 * S + 4) @(negedge clk);
        chk("mid_busy", 64'(busy8), 64'd1);
        chk("mid_entry2", 64'(buf8[2]), 64'(C_X8));
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", 64'(busy8), 64'd0);
        chk("arst_done", 64'(done8), 64'd0);
        chk("arst_buffer", 64'(buf8), 64'd0);
        start8 = 1'b1;
        @(negedge clk);
        chk("start_in_rst_ignored", 64'(busy8), 64'd0);
        rst = 1'b0;
        @(negedge clk); start8 = 1'b0;
        chk("start_after_release", 64'(busy8), 64'd1);
        wait8(0, lat);
        chk("rerun_latency", 64'(lat), 64'(L8));
        chk("rerun_buffer", 64'(buf8), 64'(exp8));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/rt_multi_worker.md
RT_MULTI_WORKER -- requirements
Module: rt_multi_worker

Interface
REQ-001 SHALL have parameter JOBS, default 8: pixels evaluated per activation.
REQ-002 SHALL have parameter STRIDE, default 4: x step between consecutive pixels (worker count).
REQ-003 SHALL have parameter N_SPHERES, default 4: spheres tested per pixel, range 1..16.
REQ-004 SHALL have parameter PIXEL_Z, default 100: constant ray z component.
REQ-005 SHALL have parameter COLOR_W, default 8: width of each buffer entry; COLOR_MAX = 2^COLOR_W-1.
REQ-006 SHALL have port clk  in  1  the single clock; all flops on rising edge.
REQ-007 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-008 SHALL have port start  in  1  one-cycle request to begin a job.
REQ-009 SHALL have port pixel_start_x  in  12 signed  x of pixel 0.
REQ-010 SHALL have port pixel_y  in  12 signed  row y.
REQ-011 SHALL have port spheres  in  Types::Sphere[N_SPHERES]  scene; held stable while busy.
REQ-012 SHALL have port busy  out  1  high from the cycle after accepted start until done.
REQ-013 SHALL have port done  out  1  one-cycle pulse when the last pixel is written.
REQ-014 SHALL have port buffer  out  COLOR_W x JOBS  per-pixel results; entry j = pixel_start_x + j*STRIDE.

Function
REQ-015 SHALL accept start only in IDLE; start while busy is ignored.
REQ-016 SHALL capture pixel_start_x and pixel_y on acceptance, clear all buffer entries, and reset job and sphere indices to 0.
REQ-017 SHALL use states IDLE, SQUARE, DOT, SUM, DISC, SHADE, NEXT; each non-IDLE state lasts one cycle.
REQ-018 SHALL per (pixel, sphere) compute a = px^2+py^2+PIXEL_Z^2, b = 2(px*sx+py*sy+PIXEL_Z*sz), c = sx^2+sy^2+sz^2-r^2, dis = b^2-4ac.
REQ-019 SHALL carry dis in a 64-bit signed register and intermediates without truncation for all 12-bit pixel and sphere field values.
REQ-020 SHALL treat dis >= 0 as a hit.
REQ-021 SHALL test spheres in ascending index order; the first hit ends the pixel (early-out), and the lowest index has priority.
REQ-022 SHALL on a miss advance to the next sphere; if the last sphere misses, the entry stays 0.
REQ-023 SHALL in NEXT write the entry, advance px by STRIDE and job index by 1, and return to SQUARE; after entry JOBS-1 SHALL pulse done, drop busy, and enter IDLE in the same cycle.
REQ-024 SHALL make the final buffer value visible on the cycle done is high and hold it until the next accepted start or reset.
REQ-025 SHALL skip SHADE when RT_SHADING_EN is undefined.
REQ-026 SHALL have worst-case per-pixel latency N_SPHERES*S+1 cycles, where S = 5 with shading and 4 without.

Reset
REQ-027 SHALL on rst, at any time including mid-job, asynchronously force IDLE, busy=0, done=0, all buffer entries 0, and indices 0.
REQ-028 SHALL ignore start while rst is high and begin accepting start on the first clk edge after release.

Configuration
REQ-029 SHALL with RT_SHADING_EN defined colour a hit as min(floor(log2(dis))+1, COLOR_MAX), with dis==0 giving 1, using a single-cycle leading-one encoder in SHADE.
REQ-030 SHALL with RT_SHADING_EN undefined colour every hit COLOR_MAX; the hit/miss decision is identical in both builds.

Verification
REQ-031 SHALL cover: sphere0=(0,0,200,r=50), others far behind, JOBS=1, pixel (0,0), shading on -> dis=100000000, buffer[0]=27, done after 6 cycles.
REQ-032 SHALL cover: same scene, pixel (100,0) -> dis<0 for all spheres, buffer[0]=0, done after N_SPHERES*5+1 cycles.
REQ-033 SHALL cover: shading off, pixel (0,0), sphere0 hit -> buffer[0]=255, latency 5.
REQ-034 SHALL cover: spheres 1 and 2 both hit, sphere 0 misses -> colour taken from sphere 1; sphere 2 never evaluated (latency 2*S+1).
REQ-035 SHALL cover: JOBS=8, STRIDE=4, start at x=-16 -> entries correspond to x=-16..12 step 4; a start pulse mid-job is ignored; exactly one done pulse.
REQ-036 SHALL cover: rst asserted at pixel 3 -> same-cycle busy=0 and buffer all 0; a new start after release completes normally.
